// File: rtl/alu_serial.sv
// alu_serial: bit-serial ALU sequencer, LSB-first over W cycles; ALU_SERIAL_BACK2BACK_EN allows DONE->RUN without an IDLE cycle.
module alu_serial #(
  parameter int W  = 32,
  parameter int CW = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         carryout,
  output logic         zero,
  output logic         overflow
);
  localparam logic [2:0] ADD  = 3'd0;
  localparam logic [2:0] SUB  = 3'd1;
  localparam logic [2:0] XOR  = 3'd2;
  localparam logic [2:0] SLT  = 3'd3;
  localparam logic [2:0] AND  = 3'd4;
  localparam logic [2:0] NAND = 3'd5;
  localparam logic [2:0] NOR  = 3'd6;
  localparam logic [2:0] OR   = 3'd7;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_nx;
  logic [W-1:0]   sa, sb, full, fin;
  logic [2:0]     sop;
  logic [CW-1:0]  cnt;
  logic           c, arith, invta, invtb, ai, bi, s, co, f, last, acc;

  // one-bit slice: AND/OR come from NOR/NAND of both operands inverted
  always_comb begin
    arith = sop == ADD || sop == SUB || sop == SLT;
    invta = sop == AND || sop == OR;
    invtb = invta || sop == SUB || sop == SLT;
    ai    = sa[0] ^ invta;
    bi    = sb[0] ^ invtb;
    s     = ai ^ bi ^ c;
    co    = (ai & bi) | (c & (ai ^ bi));
    f     = arith ? s : sop == XOR ? sa[0] ^ sb[0] : (sop == NAND || sop == OR) ? ~(ai & bi) : ~(ai | bi);
    full  = {f, result[W-1:1]};
    fin   = sop == SLT ? {{(W-1){1'b0}}, s ^ c ^ co} : full;
    last  = cnt == CW'(W - 1);
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        state_nx = in_valid ? RUN : IDLE;
      end
      RUN: state_nx = last ? DONE : RUN;
      DONE: begin
        out_valid = 1'b1;
`ifdef ALU_SERIAL_BACK2BACK_EN
        in_ready = out_ready;
        state_nx = out_ready ? (in_valid ? RUN : IDLE) : DONE;
`else
        state_nx = out_ready ? IDLE : DONE;
`endif
      end
      default: state_nx = IDLE;
    endcase
    acc = in_valid & in_ready;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sa       <= '0;
      sb       <= '0;
      sop      <= '0;
      cnt      <= '0;
      c        <= 1'b0;
      result   <= '0;
      carryout <= 1'b0;
      zero     <= 1'b0;
      overflow <= 1'b0;
    end else if (acc) begin
      sa  <= a;
      sb  <= b;
      sop <= op;
      cnt <= '0;
      c   <= op == SUB || op == SLT;
    end else if (state == RUN) begin
      sa     <= sa >> 1;
      sb     <= sb >> 1;
      c      <= co;
      cnt    <= last ? cnt : cnt + 1'b1;
      result <= last ? fin : full;
      if (last) begin
        carryout <= arith & co;
        overflow <= arith & (c ^ co);
        zero     <= fin == '0;
      end
    end
  end
endmodule

// File: tb/tb_alu_serial.sv
// tb_alu_serial: directed and randomized checks of alu_serial (W=4) against an arithmetic reference model.
module tb_alu_serial;
  localparam int W = 4;

  logic         clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [2:0]   op = '0;
  logic [W-1:0] a = '0, b = '0;
  logic         in_ready, out_valid, carryout, zero, overflow;
  logic [W-1:0] result;
  int           checks = 0, errors = 0;

  always #5 clk = ~clk;

  alu_serial #(.W(W), .CW(3)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .carryout(carryout), .zero(zero), .overflow(overflow)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {result, carryout, zero, overflow}
  function automatic logic [W+2:0] model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0]   s;
    logic [W-1:0] r;
    logic         co, ov;
    co = 1'b0;
    ov = 1'b0;
    r  = '0;
    case (o)
      3'd0: begin
        s  = {1'b0, x} + {1'b0, y};
        r  = s[W-1:0];
        co = s[W];
        ov = x[W-1] == y[W-1] && r[W-1] != x[W-1];
      end
      3'd1, 3'd3: begin
        s  = {1'b0, x} + {1'b0, ~y} + {{W{1'b0}}, 1'b1};
        r  = s[W-1:0];
        co = s[W];
        ov = x[W-1] != y[W-1] && r[W-1] != x[W-1];
        if (o == 3'd3) r = ($signed(x) < $signed(y)) ? W'(1) : '0;
      end
      3'd2: r = x ^ y;
      3'd4: r = x & y;
      3'd5: r = ~(x & y);
      3'd6: r = ~(x | y);
      default: r = x | y;
    endcase
    return {r, co, r == '0, ov};
  endfunction

  task automatic do_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input int hold, input bit poke, input logic [W+2:0] exp);
    int n;
    @(negedge clk);
    op = o; a = x; b = y; in_valid = 1'b1;
    chk("in_ready_idle", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; op = 3'($urandom); a = W'($urandom); b = W'($urandom);
    n = 0;
    while (!out_valid && n < 3 * W) begin
      in_valid = poke && n == 1;
      if (poke && n == 1) chk("in_ready_run", in_ready, 0);
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    chk("latency", n, W);
    chk($sformatf("op%0d_%h_%h", o, x, y), {result, carryout, zero, overflow}, exp);
    repeat (hold) begin
      @(posedge clk); #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_data", {result, carryout, zero, overflow}, exp);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("pop_valid", out_valid, 0);
    chk("pop_data", {result, carryout, zero, overflow}, exp);
  endtask

  initial begin
    logic [2:0]   o;
    logic [W-1:0] x, y;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_outputs", {result, carryout, zero, overflow}, 0);
    reset = 1'b0;

    do_op(3'd0, 4'b0111, 4'b1001, 0, 1'b0, 7'b0000_1_1_0);
    do_op(3'd1, 4'b0011, 4'b0101, 0, 1'b0, 7'b1110_0_0_0);
    do_op(3'd1, 4'b0111, 4'b1000, 0, 1'b0, 7'b1111_0_0_1);
    do_op(3'd3, 4'b1000, 4'b0001, 0, 1'b0, 7'b0001_1_0_1);
    do_op(3'd3, 4'b0001, 4'b1000, 0, 1'b0, 7'b0000_0_1_1);
    do_op(3'd4, 4'b1100, 4'b1010, 0, 1'b0, 7'b1000_0_0_0);
    do_op(3'd7, 4'b1100, 4'b1010, 0, 1'b0, 7'b1110_0_0_0);
    do_op(3'd2, 4'b1100, 4'b1010, 0, 1'b0, 7'b0110_0_0_0);
    do_op(3'd5, 4'b1100, 4'b1010, 0, 1'b0, 7'b0111_0_0_0);
    do_op(3'd6, 4'b1100, 4'b1010, 0, 1'b0, 7'b0001_0_0_0);
    do_op(3'd1, 4'b0111, 4'b1000, 10, 1'b1, 7'b1111_0_0_1);

    @(negedge clk);
    op = 3'd0; a = 4'b0101; b = 4'b0011; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrun_in_ready", in_ready, 1);
    chk("midrun_out_valid", out_valid, 0);
    chk("midrun_outputs", {result, carryout, zero, overflow}, 0);
    do_op(3'd0, 4'b0101, 4'b0011, 0, 1'b0, 7'b1000_0_0_1);

`ifdef ALU_SERIAL_BACK2BACK_EN
    begin
      int n;
      @(negedge clk);
      op = 3'd0; a = 4'b0001; b = 4'b0010; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 3 * W) begin @(posedge clk); #1; n++; end
      chk("b2b_first_latency", n, W);
      chk("b2b_first", {result, carryout, zero, overflow}, model(3'd0, 4'b0001, 4'b0010));
      @(negedge clk);
      out_ready = 1'b1; in_valid = 1'b1; op = 3'd0; a = 4'b0110; b = 4'b0111;
      chk("b2b_in_ready", in_ready, 1);
      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b0;
      chk("b2b_gap_valid", out_valid, 0);
      n = 0;
      while (!out_valid && n < 3 * W) begin @(posedge clk); #1; n++; end
      chk("b2b_second_latency", n, W);
      chk("b2b_second", {result, carryout, zero, overflow}, model(3'd0, 4'b0110, 4'b0111));
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
`endif

    for (int i = 0; i < 150; i++) begin
      o = 3'($urandom_range(0, 7));
      x = W'($urandom);
      y = W'($urandom);
      do_op(o, x, y, $urandom_range(0, 2), 1'($urandom_range(0, 1)), model(o, x, y));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
